// File: rtl/ram_dp_be_if.sv
// Write/read/clear bus of the byte-enable dual-port RAM.
// With RAM_PARITY_EN defined the bus also carries parity_err.
interface ram_dp_be_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 8
);
    logic                   clear;
    logic                   busy;
    logic                   write_en;
    logic [A_WIDTH-1:0]     write_addr;
    logic [D_WIDTH-1:0]     write_data;
    logic [D_WIDTH/8-1:0]   write_be;
    logic                   read_en;
    logic [A_WIDTH-1:0]     read_addr;
    logic [D_WIDTH-1:0]     read_data;
    logic                   read_valid;
`ifdef RAM_PARITY_EN
    logic                   parity_err;
`endif

    modport master (
        output clear, write_en, write_addr, write_data, write_be, read_en, read_addr,
        input  busy, read_data, read_valid
`ifdef RAM_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  clear, write_en, write_addr, write_data, write_be, read_en, read_addr,
        output busy, read_data, read_valid
`ifdef RAM_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, collision mode and clear engine.
// Optional per-byte even parity storage and checking when RAM_PARITY_EN is defined.
module ram_dp_be #(
    parameter int D_WIDTH     = 32,
    parameter int A_WIDTH     = 8,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 0
) (
    input logic        clk,
    input logic        rst_n,
    ram_dp_be_if.slave bus
);
    localparam int NB    = D_WIDTH / 8;
    localparam int DEPTH = 1 << A_WIDTH;
`ifdef RAM_PARITY_EN
    localparam int LW = 9;
`else
    localparam int LW = 8;
`endif

    // Each lane holds one data byte, with its parity bit on top when enabled.
    typedef logic [NB-1:0][LW-1:0] word_t;
    typedef enum logic {CLEAR, IDLE} state_t;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("ram_dp_be: RD_LATENCY must be 1 or 2");
    end
    if (D_WIDTH % 8 != 0) begin : g_bad_width
        $error("ram_dp_be: D_WIDTH must be a multiple of 8");
    end

    function automatic word_t encode(input logic [D_WIDTH-1:0] d);
        word_t w;
        w = '0;
        for (int i = 0; i < NB; i++) begin
            w[i][7:0] = d[8*i +: 8];
`ifdef RAM_PARITY_EN
            w[i][8] = ^d[8*i +: 8];
`endif
        end
        return w;
    endfunction

    function automatic logic [D_WIDTH-1:0] decode(input word_t w);
        logic [D_WIDTH-1:0] d;
        for (int i = 0; i < NB; i++) d[8*i +: 8] = w[i][7:0];
        return d;
    endfunction

`ifdef RAM_PARITY_EN
    function automatic logic parity_bad(input word_t w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NB; i++) bad = bad | (^w[i]);
        return bad;
    endfunction
`endif

    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] cnt, cnt_nxt;
    logic               busy;
    logic               wr_acc, rd_acc;
    word_t              wr_word, rd_word;
    word_t              mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                busy    = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) state_nxt = IDLE;
            end
            IDLE: begin
                if (bus.clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign bus.busy = busy;
    assign wr_acc   = bus.write_en & ~busy;
    assign rd_acc   = bus.read_en & ~busy;
    assign wr_word  = encode(bus.write_data);

    // p0: array write (clear engine has priority) and array read
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (bus.write_be[i]) mem[bus.write_addr][i] <= wr_word[i];
        end
    end

    always_comb begin
        rd_word = mem[bus.read_addr];
        if (WRITE_FIRST != 0 && wr_acc && bus.write_addr == bus.read_addr) begin
            for (int i = 0; i < NB; i++)
                if (bus.write_be[i]) rd_word[i] = wr_word[i];
        end
    end

    word_t out_word;
    logic  out_vld;

    // p1: optional extra register stage for the two-cycle latency
    if (RD_LATENCY == 2) begin : g_lat2
        word_t data_p1;
        logic  vld_p1;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_p1 <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= rd_acc;
                if (rd_acc) data_p1 <= rd_word;
            end
        end
        assign out_word = data_p1;
        assign out_vld  = vld_p1;
    end else begin : g_lat1
        assign out_word = rd_word;
        assign out_vld  = rd_acc;
    end

    logic [D_WIDTH-1:0] data_p2;
    logic               vld_p2;

    // p2: output register; data holds between completed reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2 <= '0;
            vld_p2  <= 1'b0;
        end else begin
            vld_p2 <= out_vld;
            if (out_vld) data_p2 <= decode(out_word);
        end
    end

    assign bus.read_data  = data_p2;
    assign bus.read_valid = vld_p2;

`ifdef RAM_PARITY_EN
    logic perr_p2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_p2 <= 1'b0;
        else        perr_p2 <= out_vld & parity_bad(out_word);
    end
    assign bus.parity_err = perr_p2;
`endif
endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: instance a (latency 1, write-first) and b (latency 2, read-first) share stimulus.
module tb_ram_dp_be;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NB = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic write_en = 1'b0;
    logic read_en = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [AW-1:0] read_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic [NB-1:0] write_be = '0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ram_dp_be_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus_a ();
    ram_dp_be_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus_b ();

    assign bus_a.clear = clear;
    assign bus_a.write_en = write_en;
    assign bus_a.write_addr = write_addr;
    assign bus_a.write_data = write_data;
    assign bus_a.write_be = write_be;
    assign bus_a.read_en = read_en;
    assign bus_a.read_addr = read_addr;
    assign bus_b.clear = clear;
    assign bus_b.write_en = write_en;
    assign bus_b.write_addr = write_addr;
    assign bus_b.write_data = write_data;
    assign bus_b.write_be = write_be;
    assign bus_b.read_en = read_en;
    assign bus_b.read_addr = read_addr;

    ram_dp_be #(.D_WIDTH(DW), .A_WIDTH(AW), .RD_LATENCY(1), .WRITE_FIRST(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    ram_dp_be #(.D_WIDTH(DW), .A_WIDTH(AW), .RD_LATENCY(2), .WRITE_FIRST(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus_a.busy === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        write_en = 1'b0;
        read_en = 1'b0;
        chk("busy_b_done", bus_b.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vec[0]  = '{1'b1, 4'd3,  32'hAABBCCDD, 4'hF, 1'b0, 4'd0,  32'h00000000, 32'h00000000};
        vec[1]  = '{1'b1, 4'd3,  32'h11223344, 4'h5, 1'b1, 4'd3,  32'hAA22CC44, 32'hAABBCCDD};
        vec[2]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  32'hAA22CC44, 32'hAA22CC44};
        vec[3]  = '{1'b1, 4'd5,  32'hFFFF0000, 4'hC, 1'b1, 4'd5,  32'hFFFF0000, 32'h00000000};
        vec[4]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd5,  32'hFFFF0000, 32'hFFFF0000};
        vec[5]  = '{1'b1, 4'd6,  32'h12345678, 4'h0, 1'b1, 4'd6,  32'h00000000, 32'h00000000};
        vec[6]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd6,  32'h00000000, 32'h00000000};
        vec[7]  = '{1'b1, 4'd7,  32'hCAFEF00D, 4'hF, 1'b1, 4'd8,  32'h00000000, 32'h00000000};
        vec[8]  = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd7,  32'hCAFEF00D, 32'hCAFEF00D};
        vec[9]  = '{1'b1, 4'd15, 32'hDEADBEEF, 4'h2, 1'b1, 4'd7,  32'hCAFEF00D, 32'hCAFEF00D};
        vec[10] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd15, 32'h0000BE00, 32'h0000BE00};
        vec[11] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 4'd0,  32'h0000BE00, 32'h0000BE00};
        vec[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 1'b1, 4'd3,  32'hAA22CC44, 32'hAA22CC44};

        // Reset state and initial clear
        repeat (3) cyc();
        chk("rst_rdata_a", bus_a.read_data, 0);
        chk("rst_valid_a", bus_a.read_valid, 0);
        chk("rst_rdata_b", bus_b.read_data, 0);
        chk("rst_valid_b", bus_b.read_valid, 0);
        chk("rst_busy_a", bus_a.busy, 1);
        rst_n = 1'b1;
        read_en = 1'b1;
        read_addr = 4'd2;
        wait_idle(n);
        chk("busy_len_init", n, 16);
        chk("busy_rd_valid_a", bus_a.read_valid, 0);
        chk("busy_rd_valid_b", bus_b.read_valid, 0);
        cyc();
        chk("idle_valid_a", bus_a.read_valid, 0);
        chk("idle_valid_b", bus_b.read_valid, 0);

        for (int i = 0; i < 16; i++) begin
            read_en = 1'b1;
            read_addr = 4'(i);
            cyc();
            chk("zero_vld_a", bus_a.read_valid, 1);
            chk("zero_data_a", bus_a.read_data, 0);
            if (i > 0) begin
                chk("zero_vld_b", bus_b.read_valid, 1);
                chk("zero_data_b", bus_b.read_data, 0);
            end
        end
        read_en = 1'b0;
        cyc();
        chk("zero_vld_b_last", bus_b.read_valid, 1);
        chk("zero_data_b_last", bus_b.read_data, 0);
        chk("zero_vld_a_end", bus_a.read_valid, 0);

        // Byte enables, collisions, no-op enables, hold behaviour
        for (int k = 0; k < 13; k++) begin
            write_en = vec[k].we;
            write_addr = vec[k].wa;
            write_data = vec[k].wd;
            write_be = vec[k].be;
            read_en = vec[k].re;
            read_addr = vec[k].ra;
            cyc();
            chk($sformatf("tbl%0d_vld_a", k), bus_a.read_valid, vec[k].re);
            chk($sformatf("tbl%0d_data_a", k), bus_a.read_data, vec[k].exp_a);
            if (k > 0) begin
                chk($sformatf("tbl%0d_vld_b", k - 1), bus_b.read_valid, vec[k-1].re);
                chk($sformatf("tbl%0d_data_b", k - 1), bus_b.read_data, vec[k-1].exp_b);
            end
        end
        write_en = 1'b0;
        read_en = 1'b0;
        cyc();
        chk("tbl12_vld_b", bus_b.read_valid, 1);
        chk("tbl12_data_b", bus_b.read_data, 32'hAA22CC44);
        chk("hold_vld_a", bus_a.read_valid, 0);
        chk("hold_data_a", bus_a.read_data, 32'hAA22CC44);

        // Two-cycle latency with back-to-back reads
        for (int i = 0; i < 3; i++) begin
            write_en = 1'b1;
            write_addr = 4'(i);
            write_data = 32'h100 + i;
            write_be = 4'hF;
            cyc();
        end
        write_en = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            read_en = 1'b1;
            read_addr = 4'(i);
            cyc();
            chk("lat_data_a", bus_a.read_data, 32'h100 + i);
            chk("lat_vld_b", bus_b.read_valid, (i == 0) ? 0 : 1);
            if (i > 0) chk("lat_data_b", bus_b.read_data, 32'h100 + i - 1);
        end
        read_en = 1'b0;
        cyc();
        chk("lat_vld_b_3", bus_b.read_valid, 1);
        chk("lat_data_b_3", bus_b.read_data, 32'h102);
        cyc();
        chk("lat_vld_b_end", bus_b.read_valid, 0);
        chk("lat_hold_b", bus_b.read_data, 32'h102);

        // Clear request with a read in flight; writes ignored while busy
        read_en = 1'b1;
        read_addr = 4'd1;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        read_en = 1'b0;
        write_en = 1'b1;
        write_addr = 4'd0;
        write_data = 32'h5A5A5A5A;
        write_be = 4'hF;
        chk("clr_vld_a", bus_a.read_valid, 1);
        chk("clr_data_a", bus_a.read_data, 32'h101);
        chk("clr_busy_a", bus_a.busy, 1);
        chk("clr_vld_b_early", bus_b.read_valid, 0);
        cyc();
        chk("clr_vld_b", bus_b.read_valid, 1);
        chk("clr_data_b", bus_b.read_data, 32'h101);
        chk("clr_busy_b", bus_b.busy, 1);
        wait_idle(n);
        chk("busy_len_req", n + 1, 16);
        read_en = 1'b1;
        read_addr = 4'd0;
        cyc();
        chk("clr_wr_ignored", bus_a.read_data, 0);
        read_addr = 4'd1;
        cyc();
        read_en = 1'b0;
        chk("clr_zeroed", bus_a.read_data, 0);

        // Reset during clear restarts the sweep
        write_en = 1'b1;
        write_addr = 4'd4;
        write_data = 32'h44;
        write_be = 4'hF;
        cyc();
        write_en = 1'b0;
        read_en = 1'b1;
        read_addr = 4'd4;
        cyc();
        read_en = 1'b0;
        cyc();
        chk("pre_rst_data_b", bus_b.read_data, 32'h44);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        repeat (7) cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_data_a", bus_a.read_data, 0);
        chk("midrst_data_b", bus_b.read_data, 0);
        chk("midrst_vld_a", bus_a.read_valid, 0);
        chk("midrst_busy_a", bus_a.busy, 1);
        cyc();
        cyc();
        rst_n = 1'b1;
        wait_idle(n);
        chk("busy_len_midrst", n, 16);
        read_en = 1'b1;
        read_addr = 4'd4;
        cyc();
        read_en = 1'b0;
        chk("midrst_vld_after", bus_a.read_valid, 1);
        chk("midrst_zeroed", bus_a.read_data, 0);

`ifdef RAM_PARITY_EN
        write_en = 1'b1;
        write_addr = 4'd10;
        write_data = 32'h01020304;
        write_be = 4'hF;
        cyc();
        write_en = 1'b0;
        u_a.mem[10][0][0] = ~u_a.mem[10][0][0];
        read_en = 1'b1;
        read_addr = 4'd10;
        cyc();
        chk("par_data", bus_a.read_data, 32'h01020305);
        chk("par_err", bus_a.parity_err, 1);
        read_addr = 4'd11;
        cyc();
        read_en = 1'b0;
        chk("par_ok_vld", bus_a.read_valid, 1);
        chk("par_ok", bus_a.parity_err, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
